alu_exec: RTL
=============

Name: alu_exec

Overview:
- Single-cycle, registered integer execute unit. Sits directly downstream of the reservation station.
- Consumes one ready instruction per cycle (exe_RS_*): computes the RV32I arithmetic/logic result or branch/jump outcome.
- Broadcasts the result on the execute CDB (ex_cdb_*), which feeds the RS, LSB and ROB wakeup/commit logic.
- Branch/jump resolution (taken flag, target) travels with the CDB packet so the ROB can detect mispredicts at commit.

Parameters:
- ROBBW, 4, ROB index width; 0 means "no dependency" and is never a valid producer tag.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, all registers hold.
- jump_wrong  in  1  ROB flush; squashes the in-flight result.
- exe_RS_flag  in  1  RS issues an instruction this cycle.
- exe_RS_V1  in  32  operand 1 (rs1 value).
- exe_RS_V2  in  32  operand 2 (rs2 value).
- exe_RS_A  in  32  immediate (already sign/shift-extended by decoder).
- exe_RS_pc  in  32  instruction pc.
- exe_RS_code  in  6  opcode per `Def.v` instruction codes (`LUI..`AND).
- exe_RS_rob_id  in  ROBBW  destination ROB tag.
- ex_cdb_flag  out  1  result valid (one cycle per accepted instruction).
- ex_cdb_rob_id  out  ROBBW  tag of the result.
- ex_cdb_val  out  32  rd writeback value.
- ex_cdb_jump  out  1  control transfer taken.
- ex_cdb_target  out  32  resolved next pc.

Behaviour:
- Reset (async, rst=1): ex_cdb_flag=0, ex_cdb_rob_id=0, ex_cdb_val=0, ex_cdb_jump=0, ex_cdb_target=0.
- Latency: inputs sampled at edge N with rdy=1 produce outputs valid after edge N. Result is combinational from inputs into output registers; no internal backpressure.
  - Throughput: 1 instruction/cycle.
- ex_cdb_flag <= exe_RS_flag on every rdy cycle. Back-to-back issues give back-to-back valids.
  - Data outputs update only when exe_RS_flag=1; otherwise they hold their previous values.
- rdy=0: every register holds, including ex_cdb_flag. A pending valid stays asserted until the first rdy=1 edge.
- jump_wrong=1 at an edge (with rdy=1): ex_cdb_flag<=0 regardless of exe_RS_flag; data registers hold.
  - jump_wrong takes priority over a simultaneous issue.
- Operation by code:
  - LUI: val=A.
  - AUIPC: val=pc+A.
  - JAL: val=pc+4, target=pc+A, jump=1.
  - JALR: val=pc+4, target=(V1+A) & ~1, jump=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: compare V1 vs V2 (signed for BLT/BGE, unsigned for *U). val=0; jump=cond; target=cond ? pc+A : pc+4.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI: V1 op A. SLTI is signed, SLTIU unsigned (A treated as 32-bit unsigned); result is 0/1.
  - SLLI/SRLI/SRAI: shift V1 by A[4:0]. SRAI is arithmetic.
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND: V1 op V2. Shift amount is V2[4:0].
  - Every non-control op: jump=0, target=pc+4.
- All arithmetic is modulo 2^32; overflow is ignored.
- Any code not listed above (including load/store codes): flag still follows issue, val=0, jump=0, target=pc+4. This must never hang.
- ex_cdb_rob_id <= exe_RS_rob_id on issue, passed through unmodified.

Test Plan:
- Reset mid-operation: issue ADD, assert rst asynchronously mid-cycle -> all outputs 0 immediately, before the next edge; after release with no issue, ex_cdb_flag stays 0.
- ADD V1=0xFFFFFFFF, V2=1, rob_id=3 -> next cycle flag=1, rob_id=3, val=0x00000000, jump=0, target=pc+4. Following idle cycle -> flag=0.
- Signed vs unsigned:
  - SLT V1=0xFFFFFFFF, V2=1 -> val=1.
  - SLTU, same operands -> val=0.
  - SRA V1=0x80000000, V2=0x21 -> val=0xC0000000 (shamt=1).
  - SRL, same operands -> val=0x40000000.
- Branch/jump, pc=0x100, A=0x20:
  - BLT V1=-1, V2=0 -> jump=1, target=0x120.
  - BLTU, same operands -> jump=0, target=0x104.
  - JALR V1=0x203, A=0 -> val=0x104, target=0x202, jump=1.
- Back-to-back plus stall: issue ADDI (rob 1) then XORI (rob 2) on consecutive cycles with rdy dropped for 2 cycles between them -> rob 1 result held with flag=1 through the stall, then rob 2 appears.
- Flush: issue LUI A=0x12345000 in the same cycle as jump_wrong=1 -> flag=0 next cycle. Issue again the next cycle -> flag=1, val=0x12345000.

Source files
------------

// File: rtl/alu_exec.sv
// Registered RV32I integer execute unit: computes ALU results and branch/jump
// resolution for one issued instruction per cycle and broadcasts it on the CDB.
module alu_exec #(
  parameter int ROBBW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jump_wrong,
  input  logic             exe_RS_flag,
  input  logic [31:0]      exe_RS_V1,
  input  logic [31:0]      exe_RS_V2,
  input  logic [31:0]      exe_RS_A,
  input  logic [31:0]      exe_RS_pc,
  input  logic [5:0]       exe_RS_code,
  input  logic [ROBBW-1:0] exe_RS_rob_id,
  output logic             ex_cdb_flag,
  output logic [ROBBW-1:0] ex_cdb_rob_id,
  output logic [31:0]      ex_cdb_val,
  output logic             ex_cdb_jump,
  output logic [31:0]      ex_cdb_target
);

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14,
    OP_LHU   = 6'd15, OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22,
    OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
    OP_OR    = 6'd36, OP_AND   = 6'd37
  } op_e;

  logic [31:0] pc_seq;
  logic [31:0] pc_off;
  logic [31:0] val_d;
  logic        jump_d;
  logic [31:0] target_d;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        imm_lt;
  logic        imm_ltu;

  assign pc_seq  = exe_RS_pc + 32'd4;
  assign pc_off  = exe_RS_pc + exe_RS_A;
  assign br_eq   = (exe_RS_V1 == exe_RS_V2);
  assign br_lt   = ($signed(exe_RS_V1) < $signed(exe_RS_V2));
  assign br_ltu  = (exe_RS_V1 < exe_RS_V2);
  assign imm_lt  = ($signed(exe_RS_V1) < $signed(exe_RS_A));
  assign imm_ltu = (exe_RS_V1 < exe_RS_A);

  always_comb begin
    val_d    = '0;
    jump_d   = 1'b0;
    target_d = pc_seq;
    case (exe_RS_code)
      OP_LUI:   val_d = exe_RS_A;
      OP_AUIPC: val_d = pc_off;
      OP_JAL: begin
        val_d    = pc_seq;
        jump_d   = 1'b1;
        target_d = pc_off;
      end
      OP_JALR: begin
        val_d    = pc_seq;
        jump_d   = 1'b1;
        target_d = (exe_RS_V1 + exe_RS_A) & ~32'd1;
      end
      OP_BEQ:   jump_d = br_eq;
      OP_BNE:   jump_d = !br_eq;
      OP_BLT:   jump_d = br_lt;
      OP_BGE:   jump_d = !br_lt;
      OP_BLTU:  jump_d = br_ltu;
      OP_BGEU:  jump_d = !br_ltu;
      OP_ADDI:  val_d = exe_RS_V1 + exe_RS_A;
      OP_SLTI:  val_d = {31'd0, imm_lt};
      OP_SLTIU: val_d = {31'd0, imm_ltu};
      OP_XORI:  val_d = exe_RS_V1 ^ exe_RS_A;
      OP_ORI:   val_d = exe_RS_V1 | exe_RS_A;
      OP_ANDI:  val_d = exe_RS_V1 & exe_RS_A;
      OP_SLLI:  val_d = exe_RS_V1 << exe_RS_A[4:0];
      OP_SRLI:  val_d = exe_RS_V1 >> exe_RS_A[4:0];
      OP_SRAI:  val_d = $signed(exe_RS_V1) >>> exe_RS_A[4:0];
      OP_ADD:   val_d = exe_RS_V1 + exe_RS_V2;
      OP_SUB:   val_d = exe_RS_V1 - exe_RS_V2;
      OP_SLL:   val_d = exe_RS_V1 << exe_RS_V2[4:0];
      OP_SLT:   val_d = {31'd0, br_lt};
      OP_SLTU:  val_d = {31'd0, br_ltu};
      OP_XOR:   val_d = exe_RS_V1 ^ exe_RS_V2;
      OP_SRL:   val_d = exe_RS_V1 >> exe_RS_V2[4:0];
      OP_SRA:   val_d = $signed(exe_RS_V1) >>> exe_RS_V2[4:0];
      OP_OR:    val_d = exe_RS_V1 | exe_RS_V2;
      OP_AND:   val_d = exe_RS_V1 & exe_RS_V2;
      default: ;
    endcase
    // Conditional branches redirect only when taken; otherwise fall through.
    if (exe_RS_code >= OP_BEQ && exe_RS_code <= OP_BGEU && jump_d)
      target_d = pc_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_cdb_flag   <= 1'b0;
      ex_cdb_rob_id <= '0;
      ex_cdb_val    <= '0;
      ex_cdb_jump   <= 1'b0;
      ex_cdb_target <= '0;
    end else if (rdy) begin
      // A flush kills both the valid and any same-cycle issue's data update.
      if (jump_wrong) begin
        ex_cdb_flag <= 1'b0;
      end else begin
        ex_cdb_flag <= exe_RS_flag;
        if (exe_RS_flag) begin
          ex_cdb_rob_id <= exe_RS_rob_id;
          ex_cdb_val    <= val_d;
          ex_cdb_jump   <= jump_d;
          ex_cdb_target <= target_d;
        end
      end
    end
  end

endmodule
